// File: rtl/pipe_ctrl_if.sv
// Hazard inputs and stall/bubble/status outputs exchanged between the
// Y86-64 datapath (master) and the pipeline control unit (slave).
interface pipe_ctrl_if #(
  parameter int CNT_W = 64
);
  logic [3:0]       D_icode;
  logic [3:0]       E_icode;
  logic [3:0]       M_icode;
  logic [3:0]       W_icode;
  logic [3:0]       d_srcA;
  logic [3:0]       d_srcB;
  logic [3:0]       E_dstM;
  logic             e_Cnd;
  logic [2:0]       m_stat;
  logic [2:0]       W_stat;

  logic             F_stall;
  logic             D_stall;
  logic             W_stall;
  logic             D_bubble;
  logic             E_bubble;
  logic             M_bubble;
  logic             W_bubble;
  logic             set_cc;
  logic [2:0]       cpu_stat;
  logic             halted;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instr_cnt;

  modport master (
    output D_icode, E_icode, M_icode, W_icode, d_srcA, d_srcB, E_dstM,
           e_Cnd, m_stat, W_stat,
    input  F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble,
           W_bubble, set_cc, cpu_stat, halted, cycle_cnt, instr_cnt
  );

  modport slave (
    input  D_icode, E_icode, M_icode, W_icode, d_srcA, d_srcB, E_dstM,
           e_Cnd, m_stat, W_stat,
    output F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble,
           W_bubble, set_cc, cpu_stat, halted, cycle_cnt, instr_cnt
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: hazard-driven stall/bubble generation, an
// INIT/RUN/HALTED processor-state FSM and cycle/instruction counters.
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 4,
  parameter int CNT_W        = 64
) (
  input  logic         clk,
  input  logic         rst,
  pipe_ctrl_if.slave   ctrl_io
);

  localparam logic [2:0] STAT_BUB = 3'd0;
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] REG_NONE = 4'hF;

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_INIT,
    S_RUN,
    S_HALTED
  } state_t;

  state_t           state_q, state_d;
  logic [FW-1:0]    flush_cnt_q, flush_cnt_d;
  logic [2:0]       halt_stat_q, halt_stat_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instr_q, instr_d;

  logic lu, rt, mp, mx, wx;
  logic unusedWIcode;

  assign unusedWIcode = ^ctrl_io.W_icode;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_INIT;
      flush_cnt_q <= '0;
      halt_stat_q <= STAT_AOK;
      cycle_q     <= '0;
      instr_q     <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      halt_stat_q <= halt_stat_d;
      cycle_q     <= cycle_d;
      instr_q     <= instr_d;
    end
  end

  always_comb begin
    lu = ((ctrl_io.E_icode == I_MRMOVQ) || (ctrl_io.E_icode == I_POPQ)) &&
         (ctrl_io.E_dstM != REG_NONE) &&
         ((ctrl_io.E_dstM == ctrl_io.d_srcA) || (ctrl_io.E_dstM == ctrl_io.d_srcB));
    rt = (ctrl_io.D_icode == I_RET) || (ctrl_io.E_icode == I_RET) ||
         (ctrl_io.M_icode == I_RET);
    mp = (ctrl_io.E_icode == I_JXX) && !ctrl_io.e_Cnd;
    mx = ctrl_io.m_stat inside {STAT_HLT, STAT_ADR, STAT_INS};
    wx = ctrl_io.W_stat inside {STAT_HLT, STAT_ADR, STAT_INS};
  end

  always_comb begin
    state_d          = state_q;
    flush_cnt_d      = flush_cnt_q;
    halt_stat_d      = halt_stat_q;
    cycle_d          = cycle_q;
    instr_d          = instr_q;
    ctrl_io.F_stall  = 1'b0;
    ctrl_io.D_stall  = 1'b0;
    ctrl_io.W_stall  = 1'b0;
    ctrl_io.D_bubble = 1'b0;
    ctrl_io.E_bubble = 1'b0;
    ctrl_io.M_bubble = 1'b0;
    ctrl_io.W_bubble = 1'b0;
    ctrl_io.set_cc   = 1'b0;
    ctrl_io.cpu_stat = STAT_AOK;

    case (state_q)
      S_INIT: begin
        ctrl_io.D_bubble = 1'b1;
        ctrl_io.E_bubble = 1'b1;
        ctrl_io.M_bubble = 1'b1;
        ctrl_io.W_bubble = 1'b1;
        flush_cnt_d      = flush_cnt_q + FW'(1);
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d     = S_RUN;
          flush_cnt_d = '0;
        end
      end
      S_RUN: begin
        // On a load/use + ret overlap D must hold the loaded-from instruction.
        ctrl_io.F_stall  = lu || rt;
        ctrl_io.D_stall  = lu;
        ctrl_io.D_bubble = mp || (rt && !lu);
        ctrl_io.E_bubble = mp || lu;
        ctrl_io.M_bubble = mx || wx;
        ctrl_io.W_stall  = wx;
        ctrl_io.set_cc   = (ctrl_io.E_icode == I_OPQ) && !mx && !wx;
        cycle_d          = cycle_q + CNT_W'(1);
        if (ctrl_io.W_stat == STAT_AOK) begin
          instr_d = instr_q + CNT_W'(1);
        end
        if (!(ctrl_io.W_stat inside {STAT_AOK, STAT_BUB})) begin
          state_d     = S_HALTED;
          halt_stat_d = ctrl_io.W_stat;
        end
      end
      S_HALTED: begin
        ctrl_io.F_stall  = 1'b1;
        ctrl_io.W_stall  = 1'b1;
        ctrl_io.M_bubble = 1'b1;
        ctrl_io.cpu_stat = halt_stat_q;
      end
      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  assign ctrl_io.halted    = (state_q == S_HALTED);
  assign ctrl_io.cycle_cnt = cycle_q;
  assign ctrl_io.instr_cnt = instr_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed hazard scenarios plus randomized
// traffic compared against a phase/counter reference model.
module tb_pipe_ctrl;

  localparam int FLUSH = 4;
  localparam int CW    = 64;

  localparam logic [7:0] CTRL_INIT   = 8'b0001_1110;
  localparam logic [7:0] CTRL_HALTED = 8'b1010_0100;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pipe_ctrl_if #(.CNT_W(CW)) bus ();

  pipe_ctrl #(
    .FLUSH_CYCLES(FLUSH),
    .CNT_W       (CW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ctrl_io(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: edges seen since reset, halt flag and counters.
  int          mFlushEdges;
  bit          mHalted;
  logic [2:0]  mHaltStat;
  logic [63:0] mCycle;
  logic [63:0] mInstr;

  function automatic logic [7:0] ctrlVec();
    return {bus.F_stall, bus.D_stall, bus.W_stall, bus.D_bubble,
            bus.E_bubble, bus.M_bubble, bus.W_bubble, bus.set_cc};
  endfunction

  function automatic logic [7:0] expCtrl();
    logic lu, rt, mp, mx, wx;
    if (mHalted) return CTRL_HALTED;
    if (mFlushEdges < FLUSH) return CTRL_INIT;
    lu = (bus.E_icode == 4'h5 || bus.E_icode == 4'hB) && bus.E_dstM != 4'hF &&
         (bus.E_dstM == bus.d_srcA || bus.E_dstM == bus.d_srcB);
    rt = (bus.D_icode == 4'h9) || (bus.E_icode == 4'h9) || (bus.M_icode == 4'h9);
    mp = (bus.E_icode == 4'h7) && !bus.e_Cnd;
    mx = (bus.m_stat >= 3'd2) && (bus.m_stat <= 3'd4);
    wx = (bus.W_stat >= 3'd2) && (bus.W_stat <= 3'd4);
    return {lu | rt, lu, wx, mp | (rt & ~lu), mp | lu, mx | wx, 1'b0,
            (bus.E_icode == 4'h6) & ~mx & ~wx};
  endfunction

  function automatic logic [2:0] expStat();
    return mHalted ? mHaltStat : 3'd1;
  endfunction

  task automatic modelReset();
    mFlushEdges = 0;
    mHalted     = 1'b0;
    mHaltStat   = 3'd1;
    mCycle      = '0;
    mInstr      = '0;
  endtask

  task automatic applyStimulus(input logic [3:0] dI, input logic [3:0] eI,
                               input logic [3:0] mI, input logic [3:0] wI,
                               input logic [3:0] sA, input logic [3:0] sB,
                               input logic [3:0] dM, input logic cnd,
                               input logic [2:0] ms, input logic [2:0] ws);
    bus.D_icode = dI;
    bus.E_icode = eI;
    bus.M_icode = mI;
    bus.W_icode = wI;
    bus.d_srcA  = sA;
    bus.d_srcB  = sB;
    bus.E_dstM  = dM;
    bus.e_Cnd   = cnd;
    bus.m_stat  = ms;
    bus.W_stat  = ws;
  endtask

  task automatic applyIdle();
    applyStimulus(4'h1, 4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd1, 3'd1);
  endtask

  // One rising edge; the model consumes the inputs that the DUT sampled.
  task automatic stepEdge();
    @(posedge clk);
    if (!mHalted) begin
      if (mFlushEdges < FLUSH) begin
        mFlushEdges++;
      end else begin
        mCycle++;
        if (bus.W_stat == 3'd1) mInstr++;
        if (bus.W_stat != 3'd0 && bus.W_stat != 3'd1) begin
          mHalted   = 1'b1;
          mHaltStat = bus.W_stat;
        end
      end
    end
    #1;
  endtask

  task automatic resetAndRun();
    @(negedge clk);
    rst = 1'b1;
    modelReset();
    applyIdle();
    #2;
    rst = 1'b0;
    for (int i = 0; i < FLUSH; i++) stepEdge();
  endtask

  task automatic test_reset();
    applyStimulus(4'h1, 4'h5, 4'h1, 4'h1, 4'h3, 4'hF, 4'h3, 1'b1, 3'd1, 3'd1);
    rst = 1'b1;
    modelReset();
    #1;
    checks++;
    if (ctrlVec() !== CTRL_INIT) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got=%b exp=%b", ctrlVec(), CTRL_INIT);
    end
    checks++;
    if (bus.cpu_stat !== 3'd1 || bus.halted !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_stat got stat=%0d halted=%b exp stat=1 halted=0",
               bus.cpu_stat, bus.halted);
    end
    checks++;
    if (bus.cycle_cnt !== 64'd0 || bus.instr_cnt !== 64'd0) begin
      errors++;
      $display("[TB] FAIL reset_counts got cyc=%0d ins=%0d exp 0/0",
               bus.cycle_cnt, bus.instr_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < FLUSH; i++) begin
      #1;
      checks++;
      if (ctrlVec() !== CTRL_INIT) begin
        errors++;
        $display("[TB] FAIL init_flush[%0d] got=%b exp=%b", i, ctrlVec(), CTRL_INIT);
      end
      stepEdge();
    end
    checks++;
    if (ctrlVec() !== 8'b1100_1000 || bus.cycle_cnt !== 64'd0) begin
      errors++;
      $display("[TB] FAIL first_run got ctrl=%b cyc=%0d exp ctrl=11001000 cyc=0",
               ctrlVec(), bus.cycle_cnt);
    end
    stepEdge();
    checks++;
    if (bus.cycle_cnt !== 64'd1 || bus.instr_cnt !== 64'd1) begin
      errors++;
      $display("[TB] FAIL first_run_count got cyc=%0d ins=%0d exp 1/1",
               bus.cycle_cnt, bus.instr_cnt);
    end
  endtask

  task automatic test_load_use();
    applyStimulus(4'h1, 4'h5, 4'h1, 4'h1, 4'hF, 4'h3, 4'h3, 1'b1, 3'd1, 3'd1);
    #1;
    checks++;
    if (ctrlVec() !== 8'b1100_1000) begin
      errors++;
      $display("[TB] FAIL load_use got=%b exp=11001000", ctrlVec());
    end
    applyStimulus(4'h1, 4'h5, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd1, 3'd1);
    #1;
    checks++;
    if (ctrlVec() !== 8'b0000_0000) begin
      errors++;
      $display("[TB] FAIL load_use_none got=%b exp=00000000", ctrlVec());
    end
    applyStimulus(4'h9, 4'hB, 4'h1, 4'h1, 4'h4, 4'hF, 4'h4, 1'b1, 3'd1, 3'd1);
    #1;
    checks++;
    if (ctrlVec() !== 8'b1100_1000) begin
      errors++;
      $display("[TB] FAIL load_use_ret got=%b exp=11001000", ctrlVec());
    end
  endtask

  task automatic test_jump_ret();
    applyStimulus(4'h1, 4'h7, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b0, 3'd1, 3'd1);
    #1;
    checks++;
    if (ctrlVec() !== 8'b0001_1000) begin
      errors++;
      $display("[TB] FAIL mispredict got=%b exp=00011000", ctrlVec());
    end
    applyStimulus(4'h1, 4'h1, 4'h9, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd1, 3'd1);
    #1;
    checks++;
    if (ctrlVec() !== 8'b1001_0000) begin
      errors++;
      $display("[TB] FAIL ret_in_m got=%b exp=10010000", ctrlVec());
    end
    stepEdge();
  endtask

  task automatic test_counters();
    resetAndRun();
    for (int i = 0; i < 10; i++) begin
      applyIdle();
      bus.W_stat = (i == 1) ? 3'd0 : 3'd1;
      stepEdge();
    end
    checks++;
    if (bus.instr_cnt !== 64'd9 || bus.cycle_cnt !== 64'd10) begin
      errors++;
      $display("[TB] FAIL counters got ins=%0d cyc=%0d exp ins=9 cyc=10",
               bus.instr_cnt, bus.cycle_cnt);
    end
  endtask

  task automatic test_random_hazards();
    logic [3:0] icodes [8];
    icodes = '{4'h0, 4'h1, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB, 4'h2};
    for (int n = 0; n < 300; n++) begin
      logic [3:0] sA, sB, dM;
      sA = ($urandom_range(0, 4) == 4) ? 4'hF : 4'($urandom_range(0, 3));
      sB = ($urandom_range(0, 4) == 4) ? 4'hF : 4'($urandom_range(0, 3));
      dM = ($urandom_range(0, 4) == 4) ? 4'hF : 4'($urandom_range(0, 3));
      applyStimulus(icodes[$urandom_range(0, 7)], icodes[$urandom_range(0, 7)],
                    icodes[$urandom_range(0, 7)], 4'($urandom_range(0, 15)),
                    sA, sB, dM, 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 1)));
      #1;
      checks++;
      if (ctrlVec() !== expCtrl() || bus.cpu_stat !== expStat()) begin
        errors++;
        $display("[TB] FAIL rand_ctrl[%0d] got=%b/%0d exp=%b/%0d", n,
                 ctrlVec(), bus.cpu_stat, expCtrl(), expStat());
      end
      checks++;
      if ((bus.D_stall && bus.D_bubble) || (bus.W_stall && bus.W_bubble) ||
          (bus.D_stall && bus.E_bubble === 1'b0)) begin
        errors++;
        $display("[TB] FAIL rand_invariant[%0d] got=%b exp no stall+bubble", n,
                 ctrlVec());
      end
      stepEdge();
      checks++;
      if (bus.cycle_cnt !== mCycle || bus.instr_cnt !== mInstr) begin
        errors++;
        $display("[TB] FAIL rand_counts[%0d] got cyc=%0d ins=%0d exp cyc=%0d ins=%0d",
                 n, bus.cycle_cnt, bus.instr_cnt, mCycle, mInstr);
      end
    end
  endtask

  task automatic test_halt();
    logic [63:0] cyc, ins;
    applyStimulus(4'h1, 4'h6, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd3, 3'd1);
    #1;
    checks++;
    if (ctrlVec() !== 8'b0000_0100) begin
      errors++;
      $display("[TB] FAIL mem_exc got=%b exp=00000100", ctrlVec());
    end
    stepEdge();
    applyStimulus(4'h1, 4'h6, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd1, 3'd3);
    #1;
    checks++;
    if (ctrlVec() !== 8'b0010_0100) begin
      errors++;
      $display("[TB] FAIL wb_exc got=%b exp=00100100", ctrlVec());
    end
    stepEdge();
    checks++;
    if (bus.halted !== 1'b1 || bus.cpu_stat !== 3'd3 || ctrlVec() !== CTRL_HALTED) begin
      errors++;
      $display("[TB] FAIL halt_enter got halted=%b stat=%0d ctrl=%b exp 1/3/%b",
               bus.halted, bus.cpu_stat, ctrlVec(), CTRL_HALTED);
    end
    cyc = bus.cycle_cnt;
    ins = bus.instr_cnt;
    checks++;
    if (cyc !== mCycle || ins !== mInstr) begin
      errors++;
      $display("[TB] FAIL halt_counts got cyc=%0d ins=%0d exp cyc=%0d ins=%0d",
               cyc, ins, mCycle, mInstr);
    end
    for (int i = 0; i < 5; i++) begin
      applyIdle();
      bus.E_icode = 4'($urandom_range(0, 15));
      stepEdge();
    end
    checks++;
    if (bus.cycle_cnt !== cyc || bus.instr_cnt !== ins || bus.cpu_stat !== 3'd3 ||
        bus.halted !== 1'b1) begin
      errors++;
      $display("[TB] FAIL halt_frozen got cyc=%0d ins=%0d stat=%0d exp cyc=%0d ins=%0d stat=3",
               bus.cycle_cnt, bus.instr_cnt, bus.cpu_stat, cyc, ins);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    checks++;
    if (ctrlVec() !== CTRL_INIT || bus.cpu_stat !== 3'd1 || bus.halted !== 1'b0 ||
        bus.cycle_cnt !== 64'd0 || bus.instr_cnt !== 64'd0) begin
      errors++;
      $display("[TB] FAIL async_reset got ctrl=%b stat=%0d halted=%b cyc=%0d exp %b/1/0/0",
               ctrlVec(), bus.cpu_stat, bus.halted, bus.cycle_cnt, CTRL_INIT);
    end
    resetAndRun();
    applyStimulus(4'h1, 4'h1, 4'h1, 4'h1, 4'hF, 4'hF, 4'hF, 1'b1, 3'd1, 3'd2);
    #1;
    stepEdge();
    checks++;
    if (bus.halted !== 1'b1 || bus.cpu_stat !== 3'd2) begin
      errors++;
      $display("[TB] FAIL hlt_after_reset got halted=%b stat=%0d exp 1/2",
               bus.halted, bus.cpu_stat);
    end
  endtask

  initial begin
    modelReset();
    applyIdle();
    test_reset();
    test_load_use();
    test_jump_ret();
    test_counters();
    test_random_hazards();
    test_halt();
    test_async_reset();
    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
